// File: rtl/uart_rx_pkg.sv
// Shared UART receive constants: frame shape, default oversampling ratio, FSM encodings.
package uart_rx_pkg;

   localparam int unsigned CLKS_PER_BIT_DEF = 16;
   localparam int unsigned DATA_BITS        = 8;
   localparam int unsigned STOP_BITS        = 1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_DATA    = 3'd2,
      ST_STOP    = 3'd3,
      ST_RECOVER = 3'd4
   } rx_state_e;

endpackage

// File: rtl/uart_rx_sipo.sv
// Serial-in parallel-out shifter: each shift pushes the new bit in at the MSB,
// so the first bit received ends up in bit 0 after WIDTH shifts (LSB-first line).
module uart_rx_sipo
   import uart_rx_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_BITS
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             shift_en_i,
   input  logic             sdata_i,
   output logic [WIDTH-1:0] pdata_o
);

   logic [WIDTH-1:0] sr_q;

   // Right-shifting register, new bit enters at the top.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr_q <= '0;
      end else if (shift_en_i) begin
         sr_q <= {sdata_i, sr_q[WIDTH-1:1]};
      end
   end

   assign pdata_o = sr_q;

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: synchronizes the line, finds the start bit, samples each
// bit at its centre and reports a good byte or a framing error with a 1-cycle pulse.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 RX_DATA_IN,
   output logic [DATA_BITS-1:0] RX_BYTE,
   output logic                 RX_DONE,
   output logic                 FRAME_ERR,
   output logic                 BUSY
);

   localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
   localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W    = $clog2(DATA_BITS);

   logic                 sync1_q;
   logic                 sync2_q;
   logic                 rx_s;
   rx_state_e            state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [IDX_W-1:0]     bit_idx_q;
   logic [DATA_BITS-1:0] byte_q;
   logic                 done_q;
   logic                 ferr_q;
   logic                 busy_q;
   logic                 full_bit_c;
   logic                 half_bit_c;
   logic                 shift_c;
   logic [DATA_BITS-1:0] shreg;

   // Two-flop synchronizer; idles high like the line.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= RX_DATA_IN;
         sync2_q <= sync1_q;
      end
   end

   assign rx_s       = sync2_q;
   assign full_bit_c = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
   assign half_bit_c = (cnt_q == CNT_W'(HALF_BIT - 1));
   assign shift_c    = (state_q == ST_DATA) && full_bit_c;

   uart_rx_sipo #(
      .WIDTH (DATA_BITS)
   ) u_sipo (
      .clk        (clk),
      .reset      (reset),
      .shift_en_i (shift_c),
      .sdata_i    (rx_s),
      .pdata_o    (shreg)
   );

   // Receive FSM with bit-timing counters and registered status outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         byte_q    <= '0;
         done_q    <= 1'b0;
         ferr_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         ferr_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               cnt_q <= '0;
               if (!rx_s) begin
                  state_q <= ST_START;
                  busy_q  <= 1'b1;
               end
            end
            ST_START: begin
               if (half_bit_c) begin
                  cnt_q <= '0;
                  if (!rx_s) begin
                     state_q   <= ST_DATA;
                     bit_idx_q <= '0;
                  end else begin
                     // Too short to be a start bit: treat as line noise.
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_DATA: begin
               if (full_bit_c) begin
                  cnt_q     <= '0;
                  bit_idx_q <= bit_idx_q + IDX_W'(1);
                  if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                     state_q <= ST_STOP;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_STOP: begin
               if (full_bit_c) begin
                  cnt_q <= '0;
                  if (rx_s) begin
                     // Leave at mid-stop so a following start edge is not missed.
                     byte_q  <= shreg;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end else begin
                     ferr_q  <= 1'b1;
                     state_q <= ST_RECOVER;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_RECOVER: begin
               // Hold off until the line is idle so a break reports only once.
               if (rx_s) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign RX_BYTE   = byte_q;
   assign RX_DONE   = done_q;
   assign FRAME_ERR = ferr_q;
   assign BUSY      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: each driven frame queues its expected pulse
// (kind, byte, arrival cycle); the monitor pops and compares on every pulse.
module tb_uart_rx;

   localparam int N = 16;
   localparam int PULSE_LAT = 155;

   typedef struct {
      logic        is_err;
      logic [7:0]  data;
      int unsigned cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] rx_byte;
   logic       rx_done;
   logic       frame_err;
   logic       busy;

   int unsigned cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   exp_t        sb_q[$];
   exp_t        mon_e;
   logic        prev_pulse = 1'b0;
   logic [7:0]  last_good = 8'h00;

   uart_rx #(.CLKS_PER_BIT(N)) dut (
      .clk        (clk),
      .reset      (reset),
      .RX_DATA_IN (rx),
      .RX_BYTE    (rx_byte),
      .RX_DONE    (rx_done),
      .FRAME_ERR  (frame_err),
      .BUSY       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic hold(input logic b, input int n);
      rx = b;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit);
      exp_t e;
      e.is_err = ~stop_bit;
      e.data   = stop_bit ? d : last_good;
      e.cyc    = cyc + PULSE_LAT;
      sb_q.push_back(e);
      if (stop_bit) last_good = d;
      hold(1'b0, N);
      for (int i = 0; i < 8; i++) hold(d[i], N);
      hold(stop_bit, N);
   endtask

   // Monitor: every status pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (reset) begin
         if (rx_done || frame_err) begin
            check_eq("pulse_exclusive", 32'(rx_done & frame_err), 0);
            check_eq("pulse_consecutive", 32'(prev_pulse), 0);
            if (sb_q.size() == 0) begin
               check_eq("unexpected_pulse", 32'({rx_done, frame_err}), 0);
            end else begin
               mon_e = sb_q.pop_front();
               check_eq("pulse_kind_ferr", 32'(frame_err), 32'(mon_e.is_err));
               check_eq("rx_byte", 32'(rx_byte), 32'(mon_e.data));
               check_eq("pulse_cycle", cyc, mon_e.cyc);
               check_eq("busy_at_pulse", 32'(busy), 32'(mon_e.is_err));
            end
         end
         prev_pulse <= rx_done | frame_err;
      end else begin
         prev_pulse <= 1'b0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [7:0] ab;
      exp_t       be;

      // Reset state
      repeat (3) @(negedge clk);
      check_eq("rst_byte", 32'(rx_byte), 0);
      check_eq("rst_done", 32'(rx_done), 0);
      check_eq("rst_ferr", 32'(frame_err), 0);
      check_eq("rst_busy", 32'(busy), 0);
      reset = 1'b1;
      repeat (5) @(negedge clk);

      // Single frame with idle gaps
      hold(1'b1, 3 * N);
      send_frame(8'hA5, 1'b1);
      hold(1'b1, 3 * N);
      check_eq("idle_busy_a5", 32'(busy), 0);

      // Back-to-back frames, no idle between stop and start
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h5A, 1'b1);
      hold(1'b1, 2 * N);

      // Start-bit glitch
      hold(1'b0, 3);
      check_eq("glitch_busy_hi", 32'(busy), 1);
      hold(1'b1, 2 * N);
      check_eq("glitch_busy_lo", 32'(busy), 0);
      send_frame(8'h3C, 1'b1);
      hold(1'b1, 2 * N);

      // Framing error after a good frame
      send_frame(8'h11, 1'b1);
      send_frame(8'h3C, 1'b0);
      check_eq("recover_busy_hi", 32'(busy), 1);
      hold(1'b1, 4);
      check_eq("recover_busy_lo", 32'(busy), 0);
      check_eq("ferr_byte_held", 32'(rx_byte), 32'h11);
      hold(1'b1, 2 * N);

      // Break: line low for 30 bit times -> one framing error
      be.is_err = 1'b1;
      be.data   = last_good;
      be.cyc    = cyc + PULSE_LAT;
      sb_q.push_back(be);
      hold(1'b0, 30 * N);
      check_eq("break_busy_hi", 32'(busy), 1);
      hold(1'b1, 2 * N);
      check_eq("break_busy_lo", 32'(busy), 0);
      send_frame(8'hC3, 1'b1);
      hold(1'b1, 2 * N);

      // Reset asserted mid-DATA, released during the final (high) data bit
      ab = 8'h96;
      hold(1'b0, N);
      for (int i = 0; i < 3; i++) hold(ab[i], N);
      rx = ab[3];
      repeat (N / 2) @(negedge clk);
      reset = 1'b0;
      #1;
      check_eq("midrst_byte", 32'(rx_byte), 0);
      check_eq("midrst_done", 32'(rx_done), 0);
      check_eq("midrst_ferr", 32'(frame_err), 0);
      check_eq("midrst_busy", 32'(busy), 0);
      repeat (N / 2) @(negedge clk);
      for (int i = 4; i < 7; i++) hold(ab[i], N);
      rx = ab[7];
      repeat (N / 2) @(negedge clk);
      reset = 1'b1;
      last_good = 8'h00;
      repeat (N / 2) @(negedge clk);
      hold(1'b1, N);
      hold(1'b1, 2 * N);
      check_eq("post_rst_busy", 32'(busy), 0);
      check_eq("post_rst_byte", 32'(rx_byte), 0);
      send_frame(8'h69, 1'b1);
      hold(1'b1, 3 * N);

      check_eq("sb_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
